fpu_wb_arbiter: RTL and testbench

- Sits downstream of the FP execution units (add/sub 4-cycle, mul 5-cycle, FMA/div 6-cycle) and upstream of the FP register file write port.
- Merges up to three same-cycle completions onto the single FP write port. Overflow results are held in a small circular queue.
- Its registered outputs drive the WB-stage FP write enable and destination used by the FP hazard scoreboard for WB forwarding.
- Asserts an issue stall when the queue nears capacity.

---
 rtl/fpu_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_fpu_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter
//   Merges same-cycle completions from the FP add/sub, multiply and FMA/div
//   units onto the single FP register-file write port. When more than one
//   result is available, older results are written first. Results that cannot
//   be written in the current cycle wait in a small circular queue.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   {add,mul,fma}_valid          unit result valid this cycle
//   {add,mul,fma}_rd             destination register
//   {add,mul,fma}_data           result value
//   {add,mul,fma}_flags          IEEE exception flags (NV, DZ, OF, UF, NX)
//   fp_reg_write_wb              registered write enable, one pulse per result
//   rd_wb, wb_data, wb_flags     registered write destination, data and flags
//   stall_issue                  queue near capacity; blocks new FP issue
//   q_count                      current queue occupancy
//   overflow_err                 sticky; a result was dropped
module fpu_wb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FLAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     add_valid,
  input  logic [4:0]               add_rd,
  input  logic [DATA_W-1:0]        add_data,
  input  logic [FLAG_W-1:0]        add_flags,
  input  logic                     mul_valid,
  input  logic [4:0]               mul_rd,
  input  logic [DATA_W-1:0]        mul_data,
  input  logic [FLAG_W-1:0]        mul_flags,
  input  logic                     fma_valid,
  input  logic [4:0]               fma_rd,
  input  logic [DATA_W-1:0]        fma_data,
  input  logic [FLAG_W-1:0]        fma_flags,
  output logic                     fp_reg_write_wb,
  output logic [4:0]               rd_wb,
  output logic [DATA_W-1:0]        wb_data,
  output logic [FLAG_W-1:0]        wb_flags,
  output logic                     stall_issue,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  entry_t           fma_e;
  entry_t           mul_e;
  entry_t           add_e;
  entry_t           cand [3];
  entry_t           enq  [3];
  logic [1:0]       n_valid;
  logic [1:0]       n_enq;
  logic [1:0]       n_acc;
  logic [CNT_W-1:0] free_slots;
  logic             deq;
  logic             bypass;
  logic             drop;

  always_comb begin
    fma_e = '{rd: fma_rd, data: fma_data, flags: fma_flags};
    mul_e = '{rd: mul_rd, data: mul_data, flags: mul_flags};
    add_e = '{rd: add_rd, data: add_data, flags: add_flags};
  end

  // Valid inputs compacted into age order (fma oldest, add youngest).
  // cand[1] is only meaningful when at least two inputs are valid; in that
  // case it is mul if fma and mul both fired, otherwise add.
  always_comb begin
    cand[0] = fma_valid ? fma_e : (mul_valid ? mul_e : add_e);
    cand[1] = (fma_valid && mul_valid) ? mul_e : add_e;
    cand[2] = add_e;
    n_valid = 2'(fma_valid) + 2'(mul_valid) + 2'(add_valid);
  end

  // A non-empty queue always dequeues its head; otherwise the oldest valid
  // input bypasses the queue. Everything else enqueues in age order, and this
  // cycle's dequeue frees a slot for this cycle's enqueues.
  always_comb begin
    deq    = (count != '0);
    bypass = !deq && (n_valid != 2'd0);
    enq    = '{default: '0};
    if (bypass) begin
      enq[0] = cand[1];
      enq[1] = cand[2];
      n_enq  = n_valid - 2'd1;
    end else begin
      enq    = cand;
      n_enq  = n_valid;
    end
    free_slots = CNT_W'(DEPTH) - count + CNT_W'(deq);
    drop       = CNT_W'(n_enq) > free_slots;
    // When dropping, free_slots < n_enq <= 3, so it fits in two bits.
    n_acc      = drop ? free_slots[1:0] : n_enq;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (i < 32'(n_acc)) begin
          mem[tail + PTR_W'(i)] <= enq[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      overflow_err    <= 1'b0;
      fp_reg_write_wb <= 1'b0;
      rd_wb           <= '0;
      wb_data         <= '0;
      wb_flags        <= '0;
    end else begin
      if (deq) begin
        fp_reg_write_wb <= 1'b1;
        rd_wb           <= mem[head].rd;
        wb_data         <= mem[head].data;
        wb_flags        <= mem[head].flags;
        head            <= head + PTR_W'(1);
      end else if (bypass) begin
        fp_reg_write_wb <= 1'b1;
        rd_wb           <= cand[0].rd;
        wb_data         <= cand[0].data;
        wb_flags        <= cand[0].flags;
      end else begin
        // Idle: destination/data/flags hold their last values.
        fp_reg_write_wb <= 1'b0;
      end
      tail  <= tail + PTR_W'(n_acc);
      count <= count + CNT_W'(n_acc) - CNT_W'(deq);
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign q_count     = count;
  assign stall_issue = (count >= CNT_W'(DEPTH - 2));

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// tb_fpu_wb_arbiter
//   Directed-vector bench for fpu_wb_arbiter (DEPTH=4, DATA_W=32, FLAG_W=5).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   1 time unit after the edge that registers them.
module tb_fpu_wb_arbiter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 5;

  localparam logic [4:0] FMA_FL = 5'h10;
  localparam logic [4:0] MUL_FL = 5'h08;
  localparam logic [4:0] ADD_FL = 5'h01;

  logic              clk = 1'b0;
  logic              rst;
  logic              add_valid, mul_valid, fma_valid;
  logic [4:0]        add_rd, mul_rd, fma_rd;
  logic [DATA_W-1:0] add_data, mul_data, fma_data;
  logic [FLAG_W-1:0] add_flags, mul_flags, fma_flags;
  logic              fp_reg_write_wb;
  logic [4:0]        rd_wb;
  logic [DATA_W-1:0] wb_data;
  logic [FLAG_W-1:0] wb_flags;
  logic              stall_issue;
  logic [2:0]        q_count;
  logic              overflow_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fpu_wb_arbiter #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .FLAG_W (FLAG_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .add_valid       (add_valid),
    .add_rd          (add_rd),
    .add_data        (add_data),
    .add_flags       (add_flags),
    .mul_valid       (mul_valid),
    .mul_rd          (mul_rd),
    .mul_data        (mul_data),
    .mul_flags       (mul_flags),
    .fma_valid       (fma_valid),
    .fma_rd          (fma_rd),
    .fma_data        (fma_data),
    .fma_flags       (fma_flags),
    .fp_reg_write_wb (fp_reg_write_wb),
    .rd_wb           (rd_wb),
    .wb_data         (wb_data),
    .wb_flags        (wb_flags),
    .stall_issue     (stall_issue),
    .q_count         (q_count),
    .overflow_err    (overflow_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad);
    fma_valid = fv; fma_rd = frd; fma_data = fd; fma_flags = FMA_FL;
    mul_valid = mv; mul_rd = mrd; mul_data = md; mul_flags = MUL_FL;
    add_valid = av; add_rd = ard; add_data = ad; add_flags = ADD_FL;
  endtask

  task automatic idle_in();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expect_wb(input string tag, input logic [4:0] rd, input logic [31:0] d,
                           input logic [4:0] fl, input logic [2:0] qc);
    check({tag, ".we"},    32'(fp_reg_write_wb), 32'd1);
    check({tag, ".rd"},    32'(rd_wb),           32'(rd));
    check({tag, ".data"},  wb_data,              d);
    check({tag, ".flags"}, 32'(wb_flags),        32'(fl));
    check({tag, ".qcnt"},  32'(q_count),         32'(qc));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".we"},   32'(fp_reg_write_wb), 32'd0);
    check({tag, ".qcnt"}, 32'(q_count),         32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    idle_in();
    tick();
    check("rst.we",    32'(fp_reg_write_wb), 32'd0);
    check("rst.rd",    32'(rd_wb),           32'd0);
    check("rst.data",  wb_data,              32'd0);
    check("rst.flags", 32'(wb_flags),        32'd0);
    check("rst.qcnt",  32'(q_count),         32'd0);
    check("rst.ovf",   32'(overflow_err),    32'd0);
    check("rst.stall", 32'(stall_issue),     32'd0);
    rst = 1'b0;
    tick();
    expect_idle("idle0");

    // Single add result
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h3F80_0000);
    add_flags = 5'h00;
    tick();
    idle_in();
    expect_wb("single", 5'd3, 32'h3F80_0000, 5'h00, 3'd0);
    tick();
    expect_idle("single.after");
    check("single.rd_hold", 32'(rd_wb), 32'd3);
    check("single.data_hold", wb_data, 32'h3F80_0000);

    // Triple collision: fma rd1, mul rd2, add rd3
    set_in(1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd3, 32'h0000_0033);
    tick();
    idle_in();
    expect_wb("tri0", 5'd1, 32'h0000_0011, FMA_FL, 3'd2);
    check("tri0.stall", 32'(stall_issue), 32'd1);
    tick();
    expect_wb("tri1", 5'd2, 32'h0000_0022, MUL_FL, 3'd1);
    check("tri1.stall", 32'(stall_issue), 32'd0);
    tick();
    expect_wb("tri2", 5'd3, 32'h0000_0033, ADD_FL, 3'd0);
    tick();
    expect_idle("tri.after");

    // WAW: fma and add both target rd5
    set_in(1'b1, 5'd5, 32'hAAAA_0000, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5555_0000);
    tick();
    idle_in();
    expect_wb("waw0", 5'd5, 32'hAAAA_0000, FMA_FL, 3'd1);
    tick();
    expect_wb("waw1", 5'd5, 32'h5555_0000, ADD_FL, 3'd0);
    tick();
    expect_idle("waw.after");

    // Wrap-around: two results per cycle for three cycles, then drain
    set_in(1'b1, 5'd6, 32'hA000_0006, 1'b1, 5'd7, 32'hB000_0007, 1'b0, 5'd0, 32'h0);
    tick();
    expect_wb("wrapA", 5'd6, 32'hA000_0006, FMA_FL, 3'd1);
    check("wrapA.stall", 32'(stall_issue), 32'd0);
    set_in(1'b1, 5'd8, 32'hC000_0008, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hD000_0009);
    tick();
    expect_wb("wrapB", 5'd7, 32'hB000_0007, MUL_FL, 3'd2);
    check("wrapB.stall", 32'(stall_issue), 32'd1);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hE000_000A, 1'b1, 5'd11, 32'hF000_000B);
    tick();
    idle_in();
    expect_wb("wrapC", 5'd8, 32'hC000_0008, FMA_FL, 3'd3);
    tick();
    expect_wb("wrapD", 5'd9, 32'hD000_0009, ADD_FL, 3'd2);
    tick();
    expect_wb("wrapE", 5'd10, 32'hE000_000A, MUL_FL, 3'd1);
    tick();
    expect_wb("wrapF", 5'd11, 32'hF000_000B, ADD_FL, 3'd0);
    tick();
    expect_idle("wrap.after");
    check("wrap.ovf", 32'(overflow_err), 32'd0);

    // Overflow: three triples back to back; N and O are dropped
    set_in(1'b1, 5'd12, 32'hC0DE_000C, 1'b1, 5'd13, 32'hC0DE_000D, 1'b1, 5'd14, 32'hC0DE_000E);
    tick();
    expect_wb("ovfG", 5'd12, 32'hC0DE_000C, FMA_FL, 3'd2);
    set_in(1'b1, 5'd15, 32'hC0DE_000F, 1'b1, 5'd16, 32'hC0DE_0010, 1'b1, 5'd17, 32'hC0DE_0011);
    tick();
    expect_wb("ovfH", 5'd13, 32'hC0DE_000D, MUL_FL, 3'd4);
    check("ovfH.err", 32'(overflow_err), 32'd0);
    check("ovfH.stall", 32'(stall_issue), 32'd1);
    set_in(1'b1, 5'd18, 32'hC0DE_0012, 1'b1, 5'd19, 32'hC0DE_0013, 1'b1, 5'd20, 32'hC0DE_0014);
    tick();
    idle_in();
    expect_wb("ovfI", 5'd14, 32'hC0DE_000E, ADD_FL, 3'd4);
    check("ovfI.err", 32'(overflow_err), 32'd1);
    tick();
    expect_wb("ovfJ", 5'd15, 32'hC0DE_000F, FMA_FL, 3'd3);
    tick();
    expect_wb("ovfK", 5'd16, 32'hC0DE_0010, MUL_FL, 3'd2);
    tick();
    expect_wb("ovfL", 5'd17, 32'hC0DE_0011, ADD_FL, 3'd1);
    tick();
    expect_wb("ovfM", 5'd18, 32'hC0DE_0012, FMA_FL, 3'd0);
    tick();
    expect_idle("ovf.after");
    check("ovf.sticky", 32'(overflow_err), 32'd1);
    check("ovf.stall", 32'(stall_issue), 32'd0);

    // Reset mid-operation with q_count=3 and inputs valid
    set_in(1'b1, 5'd21, 32'h0000_1021, 1'b1, 5'd22, 32'h0000_1022, 1'b1, 5'd23, 32'h0000_1023);
    tick();
    expect_wb("prerstP", 5'd21, 32'h0000_1021, FMA_FL, 3'd2);
    set_in(1'b1, 5'd24, 32'h0000_1024, 1'b1, 5'd25, 32'h0000_1025, 1'b0, 5'd0, 32'h0);
    tick();
    expect_wb("prerstQ", 5'd22, 32'h0000_1022, MUL_FL, 3'd3);
    rst = 1'b1;
    set_in(1'b1, 5'd26, 32'h0000_1026, 1'b1, 5'd27, 32'h0000_1027, 1'b1, 5'd28, 32'h0000_1028);
    tick();
    rst = 1'b0;
    idle_in();
    check("mrst.we",    32'(fp_reg_write_wb), 32'd0);
    check("mrst.rd",    32'(rd_wb),           32'd0);
    check("mrst.data",  wb_data,              32'd0);
    check("mrst.flags", 32'(wb_flags),        32'd0);
    check("mrst.qcnt",  32'(q_count),         32'd0);
    check("mrst.ovf",   32'(overflow_err),    32'd0);
    check("mrst.stall", 32'(stall_issue),     32'd0);
    tick();
    expect_idle("mrst.idle1");
    tick();
    expect_idle("mrst.idle2");
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd29, 32'h4049_0FDB);
    tick();
    idle_in();
    expect_wb("mrst.new", 5'd29, 32'h4049_0FDB, ADD_FL, 3'd0);
    tick();
    expect_idle("mrst.new.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
